// File: rtl/psv_pkg.sv
// Shared types and helpers for the polyphonic scale voicer.
// Voice state encoding, octave geometry and the saturating mixer adder.
package psv_pkg;

    typedef enum logic [1:0] {
        V_IDLE    = 2'd0,
        V_ACTIVE  = 2'd1,
        V_RELEASE = 2'd2
    } voice_state_t;

    localparam int SEMIS_PER_OCT = 12;

    // a+b clipped to the signed range of a w-bit word
    function automatic logic signed [31:0] sat_add(
        input logic signed [31:0] a,
        input logic signed [31:0] b,
        input int                 w
    );
        longint s;
        longint hi;
        longint lo;
        s  = longint'(a) + longint'(b);
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (s > hi) begin
            sat_add = 32'(hi);
        end else if (s < lo) begin
            sat_add = 32'(lo);
        end else begin
            sat_add = 32'(s);
        end
    endfunction

endpackage

// File: rtl/psv_voice.sv
// One voice slot: IDLE/ACTIVE/RELEASE FSM, latched tone index
// and the release-tail down-counter.
module psv_voice
    import psv_pkg::*;
#(
    parameter int TONE_W      = 6,
    parameter int RELEASE_CYC = 2500000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              press_i,
    input  logic              release_i,
    input  logic [TONE_W-1:0] tone_i,
    output voice_state_t      state_o,
    output logic [TONE_W-1:0] tone_o,
    output logic              active_o
);

    localparam int CNT_W = (RELEASE_CYC > 1) ? $clog2(RELEASE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RELEASE_CYC - 1);

    voice_state_t      state_q, state_d;
    logic [TONE_W-1:0] tone_q, tone_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= V_IDLE;
            tone_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            tone_q  <= tone_d;
            cnt_q   <= cnt_d;
        end
    end

    // a press always wins; it also revives a voice in its tail
    always_comb begin
        state_d = state_q;
        tone_d  = tone_q;
        cnt_d   = cnt_q;
        if (press_i) begin
            state_d = V_ACTIVE;
            tone_d  = tone_i;
            cnt_d   = '0;
        end else begin
            case (state_q)
                V_ACTIVE: begin
                    if (release_i) begin
                        state_d = V_RELEASE;
                        cnt_d   = CNT_LOAD;
                    end
                end
                V_RELEASE: begin
                    if (cnt_q == '0) begin
                        state_d = V_IDLE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign state_o  = state_q;
    assign tone_o   = tone_q;
    assign active_o = (state_q != V_IDLE);

endmodule

// File: rtl/poly_scale_voicer.sv
// Key events to polyphonic notes: octave register, voice allocator,
// steal pointer, per-voice tone mux and saturating L/R mixer.
module poly_scale_voicer
    import psv_pkg::*;
#(
    parameter int SAMPLE_W    = 16,
    parameter int N_TONES     = 36,
    parameter int N_VOICES    = 4,
    parameter int SEMI_W      = 4,
    parameter int OCT_RESET   = 1,
    parameter int RELEASE_CYC = 2500000
) (
    input  logic                         CLOCK_50,
    input  logic                         reset,
    input  logic                         key_valid,
    input  logic                         key_make,
    input  logic [SEMI_W-1:0]            key_semi,
    input  logic                         oct_up,
    input  logic                         oct_dn,
    input  logic                         poly_en,
    input  logic [N_TONES*SAMPLE_W-1:0]  tone_bus,
    output logic [N_VOICES-1:0]          voice_active,
    output logic signed [SAMPLE_W-1:0]   note_out_L,
    output logic signed [SAMPLE_W-1:0]   note_out_R
);

    localparam int N_OCT  = N_TONES / SEMIS_PER_OCT;
    localparam int OCT_W  = (N_OCT > 1) ? $clog2(N_OCT) : 1;
    localparam int TONE_W = (N_TONES > 1) ? $clog2(N_TONES) : 1;
    localparam int PTR_W  = $clog2(N_VOICES);
    localparam int MIX_W  = SAMPLE_W + $clog2(N_VOICES);
    localparam logic [OCT_W-1:0] OCT_MAX = OCT_W'(N_OCT - 1);
    localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(N_VOICES - 1);

    logic [OCT_W-1:0] oct_q, oct_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic signed [SAMPLE_W-1:0] note_l_q, note_l_d;
    logic signed [SAMPLE_W-1:0] note_r_q, note_r_d;

    voice_state_t      st [N_VOICES];
    logic [TONE_W-1:0] vt [N_VOICES];
    logic signed [SAMPLE_W-1:0] word [N_VOICES];

    logic [N_VOICES-1:0] press_v, rel_v;
    logic [N_VOICES-1:0] m_act, m_rel, is_idle, is_rel;

    logic [31:0]       tone_calc;
    logic              tone_ok;
    logic              press_ev, rel_ev;
    logic [TONE_W-1:0] ev_tone;

    logic signed [MIX_W-1:0] sum_l, sum_r;

    function automatic logic [N_VOICES-1:0] lowest(
        input logic [N_VOICES-1:0] x
    );
        lowest = x & (~x + 1'b1);
    endfunction

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            oct_q    <= OCT_W'(OCT_RESET);
            ptr_q    <= '0;
            note_l_q <= '0;
            note_r_q <= '0;
        end else begin
            oct_q    <= oct_d;
            ptr_q    <= ptr_d;
            note_l_q <= note_l_d;
            note_r_q <= note_r_d;
        end
    end

    // key events see the octave as it was before this edge
    always_comb begin
        tone_calc = 32'(oct_q) * 32'(SEMIS_PER_OCT) + 32'(key_semi);
        tone_ok   = (32'(key_semi) < 32'(SEMIS_PER_OCT))
                 && (tone_calc < 32'(N_TONES));
        ev_tone   = TONE_W'(tone_calc);
        press_ev  = key_valid & key_make & tone_ok;
        rel_ev    = key_valid & ~key_make & tone_ok;
    end

    always_comb begin
        oct_d = oct_q;
        if (oct_up && !oct_dn && oct_q != OCT_MAX) begin
            oct_d = oct_q + 1'b1;
        end else if (oct_dn && !oct_up && oct_q != '0) begin
            oct_d = oct_q - 1'b1;
        end
    end

    always_comb begin
        for (int v = 0; v < N_VOICES; v++) begin
            m_act[v]   = (st[v] == V_ACTIVE) && (vt[v] == ev_tone);
            m_rel[v]   = (st[v] == V_RELEASE) && (vt[v] == ev_tone);
            is_idle[v] = (st[v] == V_IDLE);
            is_rel[v]  = (st[v] == V_RELEASE);
        end
    end

    always_comb begin
        press_v = '0;
        rel_v   = '0;
        ptr_d   = ptr_q;
        if (!poly_en) begin
            // mono: voice 0 only, everything else drains
            press_v[0] = press_ev;
            rel_v[0]   = rel_ev & m_act[0];
            for (int v = 1; v < N_VOICES; v++) begin
                rel_v[v] = 1'b1;
            end
        end else begin
            if (press_ev) begin
                if (|m_act) begin
                    press_v = '0;
                end else if (|m_rel) begin
                    press_v = lowest(m_rel);
                end else if (|is_idle) begin
                    press_v = lowest(is_idle);
                end else if (|is_rel) begin
                    press_v = lowest(is_rel);
                end else begin
                    press_v[ptr_q] = 1'b1;
                    ptr_d = (ptr_q == PTR_MAX) ? '0 : ptr_q + 1'b1;
                end
            end
            if (rel_ev) begin
                rel_v = lowest(m_act);
            end
        end
    end

    for (genvar g = 0; g < N_VOICES; g++) begin : g_voice
        psv_voice #(
            .TONE_W      (TONE_W),
            .RELEASE_CYC (RELEASE_CYC)
        ) u_voice (
            .clk_i     (CLOCK_50),
            .rst_i     (reset),
            .press_i   (press_v[g]),
            .release_i (rel_v[g]),
            .tone_i    (ev_tone),
            .state_o   (st[g]),
            .tone_o    (vt[g]),
            .active_o  (voice_active[g])
        );
        assign word[g] = tone_bus[vt[g]*SAMPLE_W +: SAMPLE_W];
    end

    always_comb begin
        sum_l = '0;
        sum_r = '0;
        for (int v = 0; v < N_VOICES; v++) begin
            if (voice_active[v]) begin
                if (v % 2 == 0) begin
                    sum_l = sum_l + MIX_W'(word[v]);
                end else begin
                    sum_r = sum_r + MIX_W'(word[v]);
                end
            end
        end
        note_l_d = SAMPLE_W'(sat_add(32'(sum_l), 32'sd0, SAMPLE_W));
        note_r_d = SAMPLE_W'(sat_add(32'(sum_r), 32'sd0, SAMPLE_W));
    end

    assign note_out_L = note_l_q;
    assign note_out_R = note_r_q;

endmodule
